// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sched_pkg
// Brief    : Shared types and default sizes for the FIFO scheduler.
// Revision : 1.0
// ============================================================================
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_e;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 8;
    localparam int NREQ_DEF  = 4;

endpackage : fifo_sched_pkg
`default_nettype wire

// File: rtl/fifo_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sched_if
// Brief    : Requester, consumer and FIFO-pin bundle around the scheduler.
// Revision : 1.0
// ============================================================================
interface fifo_sched_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [NREQ-1:0]          wr_req;
    logic [NREQ-1:0][DW-1:0]  wr_data;
    logic [NREQ-1:0]          wr_gnt;
    logic                     rd_req;
    logic                     rd_gnt;
    logic                     rd_valid;
    logic [DW-1:0]            rd_data;
    logic                     fifo_wr;
    logic                     fifo_rd;
    logic [DW-1:0]            fifo_din;
    logic [DW-1:0]            fifo_qout;
    logic [OW-1:0]            occ;

    // Requesters, consumer and the FIFO itself
    modport master (
        output wr_req, wr_data, rd_req, fifo_qout,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, fifo_wr, fifo_rd, fifo_din, occ
    );

    // The scheduler
    modport slave (
        input  wr_req, wr_data, rd_req, fifo_qout,
        output wr_gnt, rd_gnt, rd_valid, rd_data, fifo_wr, fifo_rd, fifo_din, occ
    );

endinterface : fifo_sched_if
`default_nettype wire

// File: rtl/fifo_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin picker; pointer advances past the winner on enable.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [N-1:0]         req,
    input  wire logic                 en,
    output logic      [N-1:0]         gnt,
    output logic      [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fifo_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sched
// Brief    : Shares one FIFO between NREQ writers and one reader, one op/cycle.
// Revision : 1.0
// ============================================================================
module fifo_sched
    import fifo_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fifo_sched_if.slave bus
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            wr_elig;
    logic            rd_elig;
    logic            sel_wr;
    logic            sel_rd;

    op_e             last_op_q, last_op_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            fifo_wr_q, fifo_wr_d;
    logic [DW-1:0]   fifo_din_q, fifo_din_d;
    // [0] drives the FIFO rd pin, [1] marks qOut as valid one cycle later
    logic [1:0]      rd_pipe_q, rd_pipe_d;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.wr_req),
        .en    (sel_wr),
        .gnt   (arb_gnt),
        .idx   (arb_idx)
    );

    always_comb begin
        wr_elig = (|bus.wr_req) && (occ_q < OW'(DEPTH));
        rd_elig = bus.rd_req && (occ_q != '0);
        sel_wr  = 1'b0;
        sel_rd  = 1'b0;
        if (wr_elig && rd_elig) begin
            // Contested cycle: alternate against whichever op went last
            if (last_op_q == OP_WR) begin
                sel_rd = 1'b1;
            end else begin
                sel_wr = 1'b1;
            end
        end else begin
            sel_wr = wr_elig;
            sel_rd = rd_elig;
        end
    end

    always_comb begin
        last_op_d  = last_op_q;
        occ_d      = occ_q;
        fifo_wr_d  = sel_wr;
        fifo_din_d = fifo_din_q;
        rd_pipe_d  = {rd_pipe_q[0], sel_rd};
        if (sel_wr) begin
            last_op_d  = OP_WR;
            occ_d      = occ_q + OW'(1);
            fifo_din_d = bus.wr_data[arb_idx];
        end else if (sel_rd) begin
            last_op_d  = OP_RD;
            occ_d      = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_op_q  <= OP_RD;
            occ_q      <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_din_q <= '0;
            rd_pipe_q  <= '0;
        end else begin
            last_op_q  <= last_op_d;
            occ_q      <= occ_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_din_q <= fifo_din_d;
            rd_pipe_q  <= rd_pipe_d;
        end
    end

    assign bus.wr_gnt   = sel_wr ? arb_gnt : '0;
    assign bus.rd_gnt   = sel_rd;
    assign bus.fifo_wr  = fifo_wr_q;
    assign bus.fifo_rd  = rd_pipe_q[0];
    assign bus.fifo_din = fifo_din_q;
    assign bus.rd_valid = rd_pipe_q[1];
    assign bus.rd_data  = bus.fifo_qout;
    assign bus.occ      = occ_q;

endmodule : fifo_sched
`default_nettype wire

// File: tb/tb_fifo_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sched
// Brief    : Directed vector table plus hand sequences for fifo_sched.
// Revision : 1.0
// ============================================================================
module tb_fifo_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fifo_sched_if #(.NREQ(4), .DW(8), .DEPTH(8)) bus ();

    fifo_sched #(.NREQ(4), .DW(8), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural FIFO on the scheduler's pins
    logic [7:0] fq[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            bus.fifo_qout <= 8'h00;
        end else if (bus.fifo_wr && !bus.fifo_rd) begin
            fq.push_back(bus.fifo_din);
        end else if (bus.fifo_rd && !bus.fifo_wr && fq.size() > 0) begin
            bus.fifo_qout <= fq.pop_front();
        end
    end

    typedef struct {
        logic [3:0] wreq;
        logic       rreq;
        logic [3:0] gnt;
        logic       rgnt;
        logic [3:0] occ;
        logic       fwr;
        logic       frd;
        logic [7:0] din;
        logic       rv;
        logic [7:0] rdat;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic [3:0] wreq, input logic rreq,
                                input logic [3:0] gnt, input logic rgnt,
                                input logic [3:0] occ, input logic fwr,
                                input logic frd, input logic [7:0] din,
                                input logic rv, input logic [7:0] rdat);
        vec_t v;
        v.wreq = wreq; v.rreq = rreq; v.gnt = gnt; v.rgnt = rgnt; v.occ = occ;
        v.fwr = fwr; v.frd = frd; v.din = din; v.rv = rv; v.rdat = rdat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Next cycle: drive just after the edge, return at the following negedge
    task automatic apply(input logic [3:0] w, input logic r);
        @(posedge clk);
        #1;
        bus.wr_req = w;
        bus.rd_req = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        bus.wr_req = '0;
        bus.rd_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_req = '0;
        bus.rd_req = 1'b0;
        for (int i = 0; i < 4; i++) bus.wr_data[i] = 8'(8'h10 + i);

        //            wreq     rr  gnt      rg occ fwr frd din    rv rdat
        tbl[0]  = mk(4'b1111, 0, 4'b0001, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        tbl[1]  = mk(4'b1111, 0, 4'b0010, 0, 1, 1, 0, 8'h10, 0, 8'h00);
        tbl[2]  = mk(4'b1111, 0, 4'b0100, 0, 2, 1, 0, 8'h11, 0, 8'h00);
        tbl[3]  = mk(4'b1111, 0, 4'b1000, 0, 3, 1, 0, 8'h12, 0, 8'h00);
        tbl[4]  = mk(4'b1111, 0, 4'b0001, 0, 4, 1, 0, 8'h13, 0, 8'h00);
        tbl[5]  = mk(4'b1111, 0, 4'b0010, 0, 5, 1, 0, 8'h10, 0, 8'h00);
        tbl[6]  = mk(4'b1111, 0, 4'b0100, 0, 6, 1, 0, 8'h11, 0, 8'h00);
        tbl[7]  = mk(4'b1111, 0, 4'b1000, 0, 7, 1, 0, 8'h12, 0, 8'h00);
        tbl[8]  = mk(4'b1111, 0, 4'b0000, 0, 8, 1, 0, 8'h13, 0, 8'h00);
        tbl[9]  = mk(4'b1111, 0, 4'b0000, 0, 8, 0, 0, 8'h00, 0, 8'h00);
        tbl[10] = mk(4'b1111, 1, 4'b0000, 1, 8, 0, 0, 8'h00, 0, 8'h00);
        tbl[11] = mk(4'b1111, 1, 4'b0001, 0, 7, 0, 1, 8'h00, 0, 8'h00);
        tbl[12] = mk(4'b1111, 1, 4'b0000, 1, 8, 1, 0, 8'h10, 1, 8'h10);
        tbl[13] = mk(4'b1111, 1, 4'b0010, 0, 7, 0, 1, 8'h00, 0, 8'h00);
        tbl[14] = mk(4'b1111, 1, 4'b0000, 1, 8, 1, 0, 8'h11, 1, 8'h11);
        tbl[15] = mk(4'b1111, 1, 4'b0100, 0, 7, 0, 1, 8'h00, 0, 8'h00);
        tbl[16] = mk(4'b0000, 0, 4'b0000, 0, 8, 1, 0, 8'h12, 1, 8'h12);

        // Idle after reset
        do_reset();
        for (int c = 0; c < 10; c++) begin
            apply(4'b0000, 1'b0);
            chk($sformatf("idle%0d_gnt", c), 32'(bus.wr_gnt), 32'h0);
            chk($sformatf("idle%0d_rgnt", c), 32'(bus.rd_gnt), 32'h0);
            chk($sformatf("idle%0d_strobes", c), 32'({bus.fifo_wr, bus.fifo_rd, bus.rd_valid}), 32'h0);
            chk($sformatf("idle%0d_occ", c), 32'(bus.occ), 32'h0);
            chk($sformatf("idle%0d_din", c), 32'(bus.fifo_din), 32'h0);
        end

        // Fill to full, then alternate reads and writes at the full boundary
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].wreq, tbl[i].rreq);
            chk($sformatf("v%0d_gnt", i), 32'(bus.wr_gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_rgnt", i), 32'(bus.rd_gnt), 32'(tbl[i].rgnt));
            chk($sformatf("v%0d_occ", i), 32'(bus.occ), 32'(tbl[i].occ));
            chk($sformatf("v%0d_fwr", i), 32'(bus.fifo_wr), 32'(tbl[i].fwr));
            chk($sformatf("v%0d_frd", i), 32'(bus.fifo_rd), 32'(tbl[i].frd));
            chk($sformatf("v%0d_rv", i), 32'(bus.rd_valid), 32'(tbl[i].rv));
            if (tbl[i].fwr) chk($sformatf("v%0d_din", i), 32'(bus.fifo_din), 32'(tbl[i].din));
            if (tbl[i].rv) chk($sformatf("v%0d_rdat", i), 32'(bus.rd_data), 32'(tbl[i].rdat));
        end

        // Two writes then two reads: 2-cycle read latency and data order
        do_reset();
        bus.wr_data[0] = 8'hA5;
        bus.wr_data[1] = 8'h3C;
        bus.wr_data[2] = 8'h77;
        apply(4'b0001, 1'b0);
        chk("s4_gnt0", 32'(bus.wr_gnt), 32'h1);
        apply(4'b0010, 1'b0);
        chk("s4_gnt1", 32'(bus.wr_gnt), 32'h2);
        chk("s4_din0", 32'(bus.fifo_din), 32'hA5);
        apply(4'b0000, 1'b1);
        chk("s4_rgnt0", 32'(bus.rd_gnt), 32'h1);
        chk("s4_occ2", 32'(bus.occ), 32'h2);
        apply(4'b0000, 1'b1);
        chk("s4_rgnt1", 32'(bus.rd_gnt), 32'h1);
        chk("s4_frd", 32'(bus.fifo_rd), 32'h1);
        chk("s4_rv_early", 32'(bus.rd_valid), 32'h0);
        apply(4'b0000, 1'b0);
        chk("s4_rv0", 32'(bus.rd_valid), 32'h1);
        chk("s4_rdat0", 32'(bus.rd_data), 32'hA5);
        apply(4'b0000, 1'b0);
        chk("s4_rv1", 32'(bus.rd_valid), 32'h1);
        chk("s4_rdat1", 32'(bus.rd_data), 32'h3C);
        chk("s4_occ0", 32'(bus.occ), 32'h0);
        apply(4'b0000, 1'b0);
        chk("s4_rv_end", 32'(bus.rd_valid), 32'h0);

        // Read while empty is held off until a write lands
        for (int c = 0; c < 6; c++) begin
            apply(4'b0000, 1'b1);
            chk($sformatf("s5_empty%0d_rgnt", c), 32'(bus.rd_gnt), 32'h0);
        end
        apply(4'b0100, 1'b1);
        chk("s5_wgnt", 32'(bus.wr_gnt), 32'h4);
        chk("s5_rgnt_blocked", 32'(bus.rd_gnt), 32'h0);
        apply(4'b0000, 1'b1);
        chk("s5_rgnt", 32'(bus.rd_gnt), 32'h1);
        chk("s5_occ1", 32'(bus.occ), 32'h1);
        apply(4'b0000, 1'b0);
        chk("s5_rgnt_drop", 32'(bus.rd_gnt), 32'h0);
        apply(4'b0000, 1'b0);
        chk("s5_rv", 32'(bus.rd_valid), 32'h1);
        chk("s5_rdat", 32'(bus.rd_data), 32'h77);

        // Reset while a write strobe is in flight
        apply(4'b0100, 1'b0);
        chk("s6_gnt", 32'(bus.wr_gnt), 32'h4);
        @(posedge clk);
        #1;
        bus.wr_req = '0;
        chk("s6_fwr_pre", 32'(bus.fifo_wr), 32'h1);
        chk("s6_occ_pre", 32'(bus.occ), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("s6_fwr_rst", 32'(bus.fifo_wr), 32'h0);
        chk("s6_occ_rst", 32'(bus.occ), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1111, 1'b0);
        chk("s6_first_gnt", 32'(bus.wr_gnt), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_sched
`default_nettype wire
